// File: rtl/regmap_pkg.sv
// regmap_pkg: shared FSM state, special addresses, response widths and address decode for param_register_map
package regmap_pkg;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
  typedef enum logic [2:0] {AC_RW, AC_RO, AC_COMMIT, AC_ALARM, AC_ILLEGAL} addr_class_t;
  localparam logic [7:0] COMMIT_ADDR = 8'hFE;
  localparam logic [7:0] ALARM_ADDR = 8'hFD;
  localparam int RSP_ADDR_W = 8;
  localparam int RSP_PAY_W = 24;
  localparam int RSP_W = RSP_ADDR_W + RSP_PAY_W;
  localparam int ALARM_W = 8;
  // Special addresses win over the RW/RO ranges so they stay reachable for any NUM_RW/NUM_RO.
  function automatic addr_class_t addr_class(input logic [7:0] a, input logic [7:0] commit_a,
                                             input logic [7:0] alarm_a, input int num_rw, input int num_ro);
    return a == commit_a ? AC_COMMIT :
           a == alarm_a ? AC_ALARM :
           int'(a) < num_rw ? AC_RW :
           int'(a) < num_rw + num_ro ? AC_RO : AC_ILLEGAL;
  endfunction
endpackage

// File: rtl/regmap_cell.sv
// regmap_cell: one RW register with live value, staged shadow copy, dirty flag and update pulse
//   wr_live   direct write of wdata into the live value
//   wr_shadow staged write of wdata into the shadow copy, marks dirty
//   commit    copies shadow to live if dirty, always clears dirty
//   live      current live value; upd pulses the cycle after live is written
module regmap_cell
  import regmap_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_live,
  input  logic              wr_shadow,
  input  logic              commit,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] live,
  output logic              upd
);
  logic [DATA_W-1:0] live_q, live_d, shadow_q, shadow_d;
  logic dirty_q, dirty_d, upd_q, upd_d;
  always_comb begin
    live_d = wr_live ? wdata : (commit && dirty_q) ? shadow_q : live_q;
    shadow_d = wr_shadow ? wdata : shadow_q;
    dirty_d = commit ? 1'b0 : wr_shadow ? 1'b1 : dirty_q;
    upd_d = wr_live || (commit && dirty_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      live_q <= RST_VAL;
      shadow_q <= RST_VAL;
      dirty_q <= 1'b0;
      upd_q <= 1'b0;
    end else begin
      live_q <= live_d;
      shadow_q <= shadow_d;
      dirty_q <= dirty_d;
      upd_q <= upd_d;
    end
  end
  assign live = live_q;
  assign upd = upd_q;
endmodule

// File: rtl/param_register_map.sv
// param_register_map: command/response register map with shadowed RW registers, RO status channels and a sticky alarm register
//   cmd_*       command handshake (accepted in IDLE), rsp_*  response held until rsp_ready
//   shadow_mode stages RW writes until a write to COMMIT_ADDR
//   ro_in       live status inputs, alarm_in  alarm events ORed into a read-to-clear register
//   reg_out     packed live register values, reg_upd  per-register change pulse
module param_register_map
  import regmap_pkg::*;
#(
  parameter int NUM_RW = 22,
  parameter int NUM_RO = 2,
  parameter int DATA_W = 24,
  parameter logic [NUM_RW*DATA_W-1:0] RST_VALS = '0,
  parameter logic [7:0] COMMIT_ADDR = regmap_pkg::COMMIT_ADDR,
  parameter logic [7:0] ALARM_ADDR = regmap_pkg::ALARM_ADDR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_wr,
  input  logic [7:0]               cmd_addr,
  input  logic [DATA_W-1:0]        cmd_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [RSP_W-1:0]         rsp_data,
  output logic                     rsp_err,
  input  logic                     shadow_mode,
  input  logic [NUM_RO*DATA_W-1:0] ro_in,
  input  logic [ALARM_W-1:0]       alarm_in,
  output logic [NUM_RW*DATA_W-1:0] reg_out,
  output logic [NUM_RW-1:0]        reg_upd
);
  state_t state_q, state_d;
  logic wr_q, wr_d, rsp_err_q, rsp_err_d;
  logic [7:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [RSP_W-1:0] rsp_data_q, rsp_data_d;
  logic [ALARM_W-1:0] sticky_q, sticky_d;
  addr_class_t cls;
  logic exec, accept, err, commit, rd_alarm;
  logic [RSP_PAY_W-1:0] payload, rw_val, ro_val;
  logic [NUM_RW-1:0] wl, ws;
  logic [DATA_W-1:0] live [NUM_RW];
  always_comb begin
    cls = addr_class(addr_q, COMMIT_ADDR, ALARM_ADDR, NUM_RW, NUM_RO);
    exec = state_q == S_EXEC;
    accept = state_q == S_IDLE && cmd_valid;
    err = wr_q ? (cls == AC_RO || cls == AC_ALARM || cls == AC_ILLEGAL)
               : (cls == AC_COMMIT || cls == AC_ILLEGAL);
    commit = exec && wr_q && cls == AC_COMMIT;
    rd_alarm = exec && !wr_q && cls == AC_ALARM;
    rw_val = '0;
    ro_val = '0;
    wl = '0;
    ws = '0;
    for (int i = 0; i < NUM_RW; i++) rw_val = addr_q == 8'(i) ? RSP_PAY_W'(live[i]) : rw_val;
    for (int i = 0; i < NUM_RO; i++)
      ro_val = addr_q == 8'(NUM_RW + i) ? RSP_PAY_W'(ro_in[i*DATA_W +: DATA_W]) : ro_val;
    for (int i = 0; i < NUM_RW; i++) begin
      wl[i] = exec && wr_q && cls == AC_RW && !shadow_mode && addr_q == 8'(i);
      ws[i] = exec && wr_q && cls == AC_RW && shadow_mode && addr_q == 8'(i);
    end
    payload = err ? '0 :
              wr_q ? (cls == AC_RW ? RSP_PAY_W'(data_q) : '0) :
              cls == AC_RW ? rw_val :
              cls == AC_RO ? ro_val :
              cls == AC_ALARM ? RSP_PAY_W'(sticky_q) : '0;
    state_d = state_q == S_IDLE ? (cmd_valid ? S_EXEC : S_IDLE) :
              state_q == S_EXEC ? S_RESP : (rsp_ready ? S_IDLE : S_RESP);
    wr_d = accept ? cmd_wr : wr_q;
    addr_d = accept ? cmd_addr : addr_q;
    data_d = accept ? cmd_data : data_q;
    rsp_data_d = exec ? {addr_q, payload} : rsp_data_q;
    rsp_err_d = exec ? err : rsp_err_q;
    // Events arriving in the clearing cycle survive the read-clear.
    sticky_d = (rd_alarm ? '0 : sticky_q) | alarm_in;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wr_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      rsp_data_q <= '0;
      rsp_err_q <= 1'b0;
      sticky_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      data_q <= data_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q <= rsp_err_d;
      sticky_q <= sticky_d;
    end
  end
  for (genvar g = 0; g < NUM_RW; g++) begin : g_cell
    regmap_cell #(
      .DATA_W (DATA_W),
      .RST_VAL(RST_VALS[g*DATA_W +: DATA_W])
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .wr_live  (wl[g]),
      .wr_shadow(ws[g]),
      .commit   (commit),
      .wdata    (data_q),
      .live     (live[g]),
      .upd      (reg_upd[g])
    );
    assign reg_out[g*DATA_W +: DATA_W] = live[g];
  end
  assign cmd_ready = state_q == S_IDLE;
  assign rsp_valid = state_q == S_RESP;
  assign rsp_data = rsp_data_q;
  assign rsp_err = rsp_err_q;
endmodule

// File: doc/param_register_map.md
PARAM_REGISTER_MAP -- requirements
Module: param_register_map

Interface
REQ-001 SHALL have parameter NUM_RW, default 22, meaning number of read/write configuration registers, at addresses 0..NUM_RW-1.
REQ-002 SHALL have parameter NUM_RO, default 2, meaning number of read-only status channels, at addresses NUM_RW..NUM_RW+NUM_RO-1.
REQ-003 SHALL have parameter DATA_W, default 24, meaning register payload width (max 24).
REQ-004 SHALL have parameter RST_VALS, default all-zero, meaning the NUM_RW*DATA_W packed reset values, with register i in bits [i*DATA_W +: DATA_W].
REQ-005 SHALL have parameters COMMIT_ADDR = 8'hFE and ALARM_ADDR = 8'hFD, meaning the addresses of the special registers.
REQ-006 Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_wr  in  1  1 = write, 0 = read
- cmd_addr  in  8  register address
- cmd_data  in  DATA_W  write payload
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_data  out  32  {address[7:0], zero-extended payload}
- rsp_err  out  1  illegal access flag
- shadow_mode  in  1  1 = writes are staged until commit
- ro_in  in  NUM_RO*DATA_W  live status inputs
- alarm_in  in  8  alarm event bits
- reg_out  out  NUM_RW*DATA_W  live register values
- reg_upd  out  NUM_RW  one-cycle pulse when a live register changes

Function
REQ-007 SHALL run an FSM with states IDLE, EXEC and RESP; cmd_ready = 1 only in IDLE.
REQ-008 IDLE: on cmd_valid, SHALL capture cmd_wr, cmd_addr and cmd_data and move to EXEC.
REQ-009 EXEC: lasts one cycle, SHALL perform the access, load the response register and move to RESP.
REQ-010 RESP: rsp_valid = 1; rsp_data and rsp_err SHALL stay stable until rsp_ready, then the FSM returns to IDLE.
- Accept to rsp_valid latency is 2 cycles.
- Every command, read or write, gets exactly one response.
REQ-011 Write to an RW register with shadow_mode = 0: the live value SHALL update at the end of EXEC, reg_upd[i] SHALL pulse in the following cycle, and the response echoes the written value.
REQ-012 Write to an RW register with shadow_mode = 1: SHALL write the shadow copy only and set dirty[i]; the live value is unchanged and reg_upd does not pulse.
REQ-013 Write to COMMIT_ADDR: SHALL copy all dirty shadows to live in the same cycle, pulse reg_upd for those registers only, and clear all dirty bits; commit with nothing dirty is a no-op, rsp_err = 0.
REQ-014 Read of an RW register SHALL return the live value, never the shadow.
REQ-015 Read of an RO channel SHALL return ro_in sampled in the EXEC cycle.
REQ-016 Alarm register (8 bits): alarm_sticky SHALL OR in alarm_in every cycle.
- Read of ALARM_ADDR returns the sticky value and clears it.
- An alarm_in bit asserted in the clearing cycle SHALL remain set.
REQ-017 The following SHALL set rsp_err = 1, return payload 0 and change no state:
- write to an RO address or ALARM_ADDR;
- read of COMMIT_ADDR;
- any unmapped address.
REQ-018 Writes wider than DATA_W: upper cmd_data bits do not exist; payload is zero-extended to 24 bits in rsp_data[23:0].
REQ-019 Toggling shadow_mode SHALL NOT discard dirty shadows; they are applied on the next commit.
REQ-020 A non-commit RW write that overlaps a pending dirty entry SHALL overwrite that shadow value; the last write wins.

Reset
REQ-021 With rst high at a clock edge, the block SHALL return to this state:
- FSM = IDLE;
- cmd_ready = 1, rsp_valid = 0, rsp_data = 0, rsp_err = 0;
- live and shadow registers = RST_VALS;
- dirty = 0, alarm_sticky = 0, reg_upd = 0.
REQ-022 Reset during EXEC or RESP SHALL abandon the command with no response and no register or alarm side effect.

Structure
REQ-023 Package regmap_pkg SHALL hold:
- the FSM state enum;
- COMMIT_ADDR and ALARM_ADDR;
- response field widths;
- the address-class decode function (RW, RO, COMMIT, ALARM, ILLEGAL).
REQ-024 Sub-module regmap_cell SHALL implement one RW register:
- live, shadow and dirty bits;
- write, commit and upd logic;
- instantiated NUM_RW times by generate.

Verification
REQ-025 The bench SHALL cover at least these scenarios:
- After reset, read addr 0 with RST_VALS[0] = 30000 -> rsp_data = 32'h00007530, rsp_err = 0, rsp_valid 2 cycles after accept.
- shadow_mode = 1; write addr 19 = 5 and addr 20 = 7 -> reg_out unchanged and reads return old values; write COMMIT_ADDR -> both live in the same cycle, with reg_upd[19] and reg_upd[20] pulsing together exactly once.
- Write addr NUM_RW (RO channel) -> rsp_err = 1, no reg_upd; write addr 8'h80 -> rsp_err = 1.
- alarm_in = 8'h04 pulsed, then ALARM_ADDR read with alarm_in = 8'h01 in the clear cycle -> response 8'h04, next read 8'h01.
- Hold rsp_ready = 0 for 10 cycles -> rsp_data stable, cmd_ready = 0, and a queued cmd_valid is not accepted.
- Assert rst during RESP following a write -> rsp_valid = 0 next cycle and the register holds its RST_VALS value.
